// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue/response controller between the core and the fpu, with a WAIT watchdog.
// Optional `FPU_ISSUE_FLAGS_EN adds rsp_flags = {nan, inf, zero} registered with the result.
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  output logic             fpu_start,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
`ifdef FPU_ISSUE_FLAGS_EN
  output logic [2:0]       rsp_flags,
`endif
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             to_q, to_d;
  logic             ready_q, start_q, valid_q, busy_q;

  // Next-state and datapath capture decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    res_d   = res_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          tag_d   = req_tag;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over the watchdog firing on the same edge
        if (fpu_done) begin
          res_d   = fpu_r;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = QNAN;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand/result registers and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      op_q    <= 2'b00;
      tag_q   <= '0;
      res_q   <= 32'h0;
      to_q    <= 1'b0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      to_q    <= to_d;
      ready_q <= (state_d == S_IDLE);
      start_q <= (state_d == S_ISSUE);
      valid_q <= (state_d == S_RESP);
      busy_q  <= (state_d != S_IDLE);
    end
  end

`ifdef FPU_ISSUE_FLAGS_EN
  function automatic logic [2:0] fp_flags(input logic [31:0] v);
    logic exp_ones, man_zero;
    exp_ones = (v[30:23] == 8'hFF);
    man_zero = (v[22:0] == 23'h0);
    return {exp_ones & ~man_zero, exp_ones & man_zero, (v[30:0] == 31'h0)};
  endfunction

  logic [2:0] flags_q;

  // Flags are decoded from the value about to be captured so they track rsp_result exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= fp_flags(res_d);
    end
  end

  assign rsp_flags = flags_q;
`endif

  assign req_ready   = ready_q;
  assign fpu_start   = start_q;
  assign rsp_valid   = valid_q;
  assign busy        = busy_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign fpu_op      = op_q;
  assign rsp_result  = res_q;
  assign rsp_tag     = tag_q;
  assign rsp_timeout = to_q;

endmodule
